// File: rtl/sig_event_monitor.sv
// sig_event_monitor
// Watches NCH channels of W-bit signals and logs value events as
// {channel, data, timestamp} records into an internal first-word-fall-through
// FIFO, which is read out over a valid/ready port.
//
// Capture modes (mode input):
//   0 OFF      no new events
//   1 MONITOR  log on value change, plus one arm record when a channel is
//              enabled or the mode enters MONITOR
//   2 STROBE   log every enabled channel on strobe_i
//   3 DISPLAY  log every enabled channel every cycle
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   sig_in[NCH*W]       monitored signals, channel c = sig_in[c*W +: W]
//   ch_en[NCH]          per-channel enable
//   mode[2], strobe_i   capture mode and strobe pulse
//   ev_valid/ev_ready   FIFO head handshake
//   ev_ch/ev_data/ev_ts FIFO head record (held when ev_valid=0)
//   ev_count            FIFO occupancy
//   lost, clr_lost      sticky coalesce/drop flag and its clear
module sig_event_monitor #(
  parameter int NCH   = 4,
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int TSW   = 16,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH*W-1:0]   sig_in,
  input  logic [NCH-1:0]     ch_en,
  input  logic [1:0]         mode,
  input  logic               strobe_i,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic [CHW-1:0]     ev_ch,
  output logic [W-1:0]       ev_data,
  output logic [TSW-1:0]     ev_ts,
  output logic [CW-1:0]      ev_count,
  output logic               lost,
  input  logic               clr_lost
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_MONITOR = 2'd1,
    MODE_STROBE  = 2'd2,
    MODE_DISPLAY = 2'd3
  } mode_e;

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic [W-1:0]   data;
    logic [TSW-1:0] ts;
  } rec_t;

  // Capture state
  logic [TSW-1:0]          r_ts;
  logic [NCH-1:0][W-1:0]   r_shadow;
  logic [NCH-1:0]          r_pend;
  logic [NCH-1:0][W-1:0]   r_pdata;
  logic [NCH-1:0][TSW-1:0] r_pts;
  logic [NCH-1:0]          r_en_q;
  mode_e                   r_mode_q;
  logic [CHW-1:0]          r_rr;
  logic                    r_lost;

  // FIFO state
  rec_t                    r_mem [DEPTH];
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;
  rec_t                    r_head;

  logic [NCH-1:0][W-1:0]   w_sig;
  logic [NCH-1:0]          w_trig;
  logic [NCH-1:0]          w_drain;
  logic [NCH-1:0]          w_coal;
  logic [CHW-1:0]          w_sel;
  logic                    w_any;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_push;
  rec_t                    w_push_rec;
  logic [AW-1:0]           w_rd_ptr_nxt;
  logic [CW-1:0]           w_count_nxt;
  rec_t                    w_head_nxt;

  assign w_sig = sig_in;

  // Per-channel trigger. In MONITOR a channel also fires once when it has
  // just been enabled or when the mode has just switched into MONITOR, so the
  // consumer always sees an initial value before any change records.
  // NOTE: every output of a combinational block gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_trig = '0;
    for (int c = 0; c < NCH; c++) begin
      case (mode_e'(mode))
        MODE_MONITOR: w_trig[c] = ch_en[c] & ((w_sig[c] != r_shadow[c]) |
                                              ~r_en_q[c] |
                                              (r_mode_q != MODE_MONITOR));
        MODE_STROBE:  w_trig[c] = ch_en[c] & strobe_i;
        MODE_DISPLAY: w_trig[c] = ch_en[c];
        default:      w_trig[c] = 1'b0;
      endcase
    end
  end

  // Round-robin pick among pending channels, starting after the last pushed.
  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      if (!w_any && r_pend[(int'(r_rr) + i) % NCH]) begin
        w_any = 1'b1;
        w_sel = CHW'((int'(r_rr) + i) % NCH);
      end
    end
  end

  assign w_full       = (r_count == CW'(DEPTH));
  assign w_pop        = (r_count != '0) & ev_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_push       = w_any & (~w_full | w_pop);
  assign w_push_rec   = '{ch: w_sel, data: r_pdata[w_sel], ts: r_pts[w_sel]};
  assign w_rd_ptr_nxt = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
  assign w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);

  // Next head: the write slot only coincides with the next read slot when the
  // FIFO would otherwise be empty, so the record being pushed bypasses memory.
  assign w_head_nxt   = (w_push && (r_wr_ptr == w_rd_ptr_nxt)) ? w_push_rec
                                                               : r_mem[w_rd_ptr_nxt];

  // A trigger on a channel that still holds an undrained event overwrites it.
  always_comb begin
    w_drain = '0;
    w_coal  = '0;
    for (int c = 0; c < NCH; c++) begin
      w_drain[c] = w_push && (w_sel == CHW'(c));
      w_coal[c]  = w_trig[c] & r_pend[c] & ~w_drain[c];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ts     <= '0;
      r_shadow <= '0;
      r_pend   <= '0;
      r_pdata  <= '0;
      r_pts    <= '0;
      r_en_q   <= '0;
      r_mode_q <= MODE_OFF;
      r_rr     <= CHW'(NCH - 1);
      r_lost   <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      r_ts     <= r_ts + 1'b1;
      r_shadow <= w_sig;
      r_en_q   <= ch_en;
      r_mode_q <= mode_e'(mode);

      for (int c = 0; c < NCH; c++) begin
        if (w_trig[c]) begin
          r_pend[c]  <= 1'b1;
          r_pdata[c] <= w_sig[c];
          r_pts[c]   <= r_ts;
        end else if (w_drain[c]) begin
          r_pend[c]  <= 1'b0;
        end
      end

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_rr     <= w_sel;
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      // Head holds its last value while the FIFO is empty.
      if (w_count_nxt != '0) r_head <= w_head_nxt;

      // Set wins over clear.
      if (|w_coal)       r_lost <= 1'b1;
      else if (clr_lost) r_lost <= 1'b0;
    end
  end

  // NOTE: the record storage has no reset; occupancy and pointers alone
  // decide which entries are meaningful, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_rec;
  end

  assign ev_valid = (r_count != '0);
  assign ev_ch    = r_head.ch;
  assign ev_data  = r_head.data;
  assign ev_ts    = r_head.ts;
  assign ev_count = r_count;
  assign lost     = r_lost;

endmodule

// File: tb/tb_sig_event_monitor.sv
// Testbench for sig_event_monitor. Two instances share all inputs:
// u_dut (DEPTH=4, TSW=16) for the functional scenarios and u_wrap
// (DEPTH=16, TSW=4) for timestamp wrap-around. Expected records are queued
// when stimulus is applied and compared as the DUT presents them.
module tb_sig_event_monitor;

  typedef struct packed {
    logic [1:0]  ch;
    logic [7:0]  data;
    logic [15:0] ts;
  } rec_t;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
    logic [3:0] ts;
  } wrec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] sig_in;
  logic [3:0]  ch_en;
  logic [1:0]  mode;
  logic        strobe_i;
  logic        ev_ready;
  logic        clr_lost;

  logic        ev_valid;
  logic [1:0]  ev_ch;
  logic [7:0]  ev_data;
  logic [15:0] ev_ts;
  logic [2:0]  ev_count;
  logic        lost;

  logic        w_ev_valid;
  logic [1:0]  w_ev_ch;
  logic [7:0]  w_ev_data;
  logic [3:0]  w_ev_ts;
  logic [4:0]  w_ev_count;
  logic        w_lost;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] tb_ts = '0;
  rec_t        exp_q[$];
  wrec_t       wrap_q[$];

  sig_event_monitor #(.NCH(4), .W(8), .DEPTH(4), .TSW(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .ch_en(ch_en), .mode(mode),
    .strobe_i(strobe_i), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_ch(ev_ch), .ev_data(ev_data), .ev_ts(ev_ts), .ev_count(ev_count),
    .lost(lost), .clr_lost(clr_lost)
  );

  sig_event_monitor #(.NCH(4), .W(8), .DEPTH(16), .TSW(4)) u_wrap (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .ch_en(ch_en), .mode(mode),
    .strobe_i(strobe_i), .ev_valid(w_ev_valid), .ev_ready(ev_ready),
    .ev_ch(w_ev_ch), .ev_data(w_ev_data), .ev_ts(w_ev_ts), .ev_count(w_ev_count),
    .lost(w_lost), .clr_lost(clr_lost)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock; tb_ts tracks the DUT timestamp counter after the edge.
  task automatic cyc();
    @(posedge clk);
    if (!rst_n) tb_ts = '0;
    else        tb_ts = tb_ts + 16'd1;
    #1;
  endtask

  task automatic set_ch(input int c, input logic [7:0] v);
    sig_in[c*8 +: 8] = v;
  endtask

  // Drain the scoreboard: compare each presented head, then expect idle.
  task automatic collect(input string name, input int budget);
    int   waited;
    rec_t e;
    waited   = 0;
    ev_ready = 1'b1;
    while (exp_q.size() > 0 && waited < budget) begin
      if (ev_valid) begin
        e = exp_q.pop_front();
        n_vec++;
        if ({ev_ch, ev_data, ev_ts} !== e) begin
          n_err++;
          $display("FAIL %s_rec: got ch=%0d data=%h ts=%0d, want ch=%0d data=%h ts=%0d",
                   name, ev_ch, ev_data, ev_ts, e.ch, e.data, e.ts);
        end
      end
      cyc();
      waited++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_timeout: %0d records still missing, want 0", name, exp_q.size());
    end
    exp_q.delete();
    cyc();
    n_vec++;
    if (ev_valid !== 1'b0 || ev_count !== 3'd0) begin
      n_err++;
      $display("FAIL %s_extra: got valid=%b count=%0d, want valid=0 count=0",
               name, ev_valid, ev_count);
    end
    ev_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sig_in = '0; ch_en = '0; mode = 2'd0;
    strobe_i = 1'b0; ev_ready = 1'b0; clr_lost = 1'b0;
    cyc(); cyc();
    n_vec++;
    if (ev_valid !== 1'b0 || ev_count !== 3'd0) begin
      n_err++;
      $display("FAIL reset_fifo: got valid=%b count=%0d, want 0 0", ev_valid, ev_count);
    end
    n_vec++;
    if ({ev_ch, ev_data, ev_ts} !== 26'd0) begin
      n_err++;
      $display("FAIL reset_head: got ch=%0d data=%h ts=%0d, want 0", ev_ch, ev_data, ev_ts);
    end
    n_vec++;
    if (lost !== 1'b0) begin
      n_err++;
      $display("FAIL reset_lost: got %b want 0", lost);
    end
    n_vec++;
    if (w_ev_valid !== 1'b0 || w_ev_count !== 5'd0) begin
      n_err++;
      $display("FAIL reset_wrap: got valid=%b count=%0d, want 0 0", w_ev_valid, w_ev_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_monitor();
    ev_ready = 1'b0; ch_en = 4'b0001; mode = 2'd1; sig_in = '0;
    exp_q.push_back('{ch: 2'd0, data: 8'h00, ts: tb_ts});
    cyc();
    while (tb_ts < 16'd10) cyc();
    set_ch(0, 8'h5A);
    exp_q.push_back('{ch: 2'd0, data: 8'h5A, ts: tb_ts});
    cyc(); cyc(); cyc(); cyc();
    n_vec++;
    if (ev_count !== 3'd2 || ev_valid !== 1'b1) begin
      n_err++;
      $display("FAIL monitor_count: got count=%0d valid=%b, want 2 1", ev_count, ev_valid);
    end
    collect("monitor", 20);
  endtask

  task automatic test_simultaneous();
    rec_t e;
    ch_en = 4'b1111;
    for (int c = 1; c < 4; c++) exp_q.push_back('{ch: 2'(c), data: 8'h00, ts: tb_ts});
    cyc();
    collect("arm", 20);
    ev_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      set_ch(c, 8'(8'h11 * (c + 1)));
      exp_q.push_back('{ch: 2'(c), data: 8'(8'h11 * (c + 1)), ts: tb_ts});
    end
    cyc();
    cyc();
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      n_vec++;
      if (ev_valid !== 1'b1 || {ev_ch, ev_data, ev_ts} !== e) begin
        n_err++;
        $display("FAIL simul_rec%0d: got v=%b ch=%0d data=%h ts=%0d, want ch=%0d data=%h ts=%0d",
                 i, ev_valid, ev_ch, ev_data, ev_ts, e.ch, e.data, e.ts);
      end
      cyc();
    end
    n_vec++;
    if (lost !== 1'b0 || ev_valid !== 1'b0) begin
      n_err++;
      $display("FAIL simul_end: got lost=%b valid=%b, want 0 0", lost, ev_valid);
    end
    exp_q.delete();
    ev_ready = 1'b0;
  endtask

  task automatic test_display_full();
    rec_t last;
    ev_ready = 1'b0; ch_en = 4'b0001; mode = 2'd3;
    for (int i = 0; i < 8; i++) begin
      set_ch(0, 8'(8'h10 + i));
      last = '{ch: 2'd0, data: 8'(8'h10 + i), ts: tb_ts};
      if (i < 4) exp_q.push_back(last);
      cyc();
    end
    n_vec++;
    if (ev_count !== 3'd4 || ev_valid !== 1'b1 || lost !== 1'b1) begin
      n_err++;
      $display("FAIL full_state: got count=%0d valid=%b lost=%b, want 4 1 1",
               ev_count, ev_valid, lost);
    end
    n_vec++;
    if ({ev_ch, ev_data, ev_ts} !== exp_q[0]) begin
      n_err++;
      $display("FAIL full_head: got data=%h ts=%0d, want data=%h ts=%0d",
               ev_data, ev_ts, exp_q[0].data, exp_q[0].ts);
    end
    clr_lost = 1'b1;
    set_ch(0, 8'h18);
    last = '{ch: 2'd0, data: 8'h18, ts: tb_ts};
    cyc();
    clr_lost = 1'b0; mode = 2'd0;
    n_vec++;
    if (lost !== 1'b1) begin
      n_err++;
      $display("FAIL full_clr_while_full: got lost=%b want 1", lost);
    end
    n_vec++;
    if ({ev_ch, ev_data, ev_ts} !== exp_q[0]) begin
      n_err++;
      $display("FAIL full_head_hold: got data=%h ts=%0d, want data=%h ts=%0d",
               ev_data, ev_ts, exp_q[0].data, exp_q[0].ts);
    end
    exp_q.push_back(last);
    collect("display", 30);
    clr_lost = 1'b1;
    cyc();
    clr_lost = 1'b0;
    n_vec++;
    if (lost !== 1'b0) begin
      n_err++;
      $display("FAIL lost_clear: got %b want 0", lost);
    end
  endtask

  task automatic test_strobe();
    rst_n = 1'b0; mode = 2'd0; ch_en = '0;
    cyc();
    rst_n = 1'b1; exp_q.delete();
    mode = 2'd2; ch_en = 4'b1010; ev_ready = 1'b1;
    while (tb_ts < 16'd20) begin
      sig_in = $urandom;
      cyc();
      n_vec++;
      if (ev_valid !== 1'b0) begin
        n_err++;
        $display("FAIL strobe_idle: got valid=%b at ts=%0d, want 0", ev_valid, tb_ts);
      end
    end
    sig_in = 32'hC4B3A291;
    strobe_i = 1'b1;
    exp_q.push_back('{ch: 2'd1, data: 8'hA2, ts: tb_ts});
    exp_q.push_back('{ch: 2'd3, data: 8'hC4, ts: tb_ts});
    cyc();
    strobe_i = 1'b0;
    sig_in = 32'h01020304;
    collect("strobe", 20);
  endtask

  task automatic test_coalesce();
    rec_t last;
    rec_t e;
    ev_ready = 1'b0; mode = 2'd1; ch_en = 4'b0001;
    for (int j = 0; j < 4; j++) begin
      set_ch(0, 8'(8'hA0 + j));
      exp_q.push_back('{ch: 2'd0, data: 8'(8'hA0 + j), ts: tb_ts});
      cyc();
    end
    cyc(); cyc();
    n_vec++;
    if (ev_count !== 3'd4 || lost !== 1'b0) begin
      n_err++;
      $display("FAIL coal_fill: got count=%0d lost=%b, want 4 0", ev_count, lost);
    end
    for (int j = 0; j < 3; j++) begin
      set_ch(0, 8'(j + 1));
      last = '{ch: 2'd0, data: 8'(j + 1), ts: tb_ts};
      cyc();
    end
    cyc();
    n_vec++;
    if (lost !== 1'b1 || ev_count !== 3'd4) begin
      n_err++;
      $display("FAIL coal_lost: got lost=%b count=%0d, want 1 4", lost, ev_count);
    end
    ev_ready = 1'b1;
    e = exp_q.pop_front();
    n_vec++;
    if ({ev_ch, ev_data, ev_ts} !== e) begin
      n_err++;
      $display("FAIL coal_pop: got data=%h ts=%0d, want data=%h ts=%0d",
               ev_data, ev_ts, e.data, e.ts);
    end
    cyc();
    ev_ready = 1'b0;
    n_vec++;
    if (ev_count !== 3'd4) begin
      n_err++;
      $display("FAIL coal_refill: got count=%0d want 4", ev_count);
    end
    exp_q.push_back(last);
    collect("coalesce", 20);
  endtask

  task automatic test_reset_mid();
    ev_ready = 1'b0; mode = 2'd3; ch_en = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      set_ch(0, 8'(8'h60 + i));
      cyc();
    end
    mode = 2'd0;
    cyc();
    n_vec++;
    if (ev_count !== 3'd3) begin
      n_err++;
      $display("FAIL mid_queued: got count=%0d want 3", ev_count);
    end
    rst_n = 1'b0;
    cyc();
    n_vec++;
    if (ev_valid !== 1'b0 || ev_count !== 3'd0 || lost !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: got valid=%b count=%0d lost=%b, want 0 0 0",
               ev_valid, ev_count, lost);
    end
    exp_q.delete();
    rst_n = 1'b1; mode = 2'd1; ch_en = 4'b0001;
    set_ch(0, 8'h77);
    exp_q.push_back('{ch: 2'd0, data: 8'h77, ts: 16'd0});
    cyc();
    collect("post_reset", 20);
  endtask

  task automatic test_wrap();
    wrec_t e;
    rst_n = 1'b0; mode = 2'd0; ch_en = '0;
    cyc();
    rst_n = 1'b1; wrap_q.delete();
    ch_en = 4'b0001; mode = 2'd3; ev_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_ch(0, 8'(8'h40 + i));
      wrap_q.push_back('{ch: 2'd0, data: 8'(8'h40 + i), ts: tb_ts[3:0]});
      cyc();
      if (i >= 1) begin
        e = wrap_q.pop_front();
        n_vec++;
        if (w_ev_valid !== 1'b1 || {w_ev_ch, w_ev_data, w_ev_ts} !== e) begin
          n_err++;
          $display("FAIL wrap_rec%0d: got v=%b data=%h ts=%0d, want data=%h ts=%0d",
                   i - 1, w_ev_valid, w_ev_data, w_ev_ts, e.data, e.ts);
        end
      end
    end
    mode = 2'd0;
    cyc();
    e = wrap_q.pop_front();
    n_vec++;
    if (w_ev_valid !== 1'b1 || {w_ev_ch, w_ev_data, w_ev_ts} !== e) begin
      n_err++;
      $display("FAIL wrap_last: got v=%b data=%h ts=%0d, want data=%h ts=%0d",
               w_ev_valid, w_ev_data, w_ev_ts, e.data, e.ts);
    end
    cyc();
    n_vec++;
    if (w_ev_valid !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_idle: got valid=%b want 0", w_ev_valid);
    end
    ev_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_monitor();
    test_simultaneous();
    test_display_full();
    test_strobe();
    test_coalesce();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
